// File: rtl/instr_mem_ctrl.sv
// Instruction memory controller.
// Fills the whole array with NOP_WORD after reset (INIT), then serves
// loader writes and 1-cycle-latency fetches with write-first bypass (READY).
// Ports:
//   clk, reset       : clock, synchronous active-high reset
//   ld_we/addr/data  : loader write port, ld_ready high when writes are taken
//   f_req/addr       : fetch request, f_ready high when a request is taken
//   f_stall          : consumer stall, freezes the fetch output while valid
//   instruction      : fetched word, f_valid marks a completed fetch,
//                      f_err marks an out-of-range fetch address
module instr_mem_ctrl #(
  parameter int unsigned       DEPTH      = 4096,
  parameter int unsigned       WIDTH      = 32,
  parameter int unsigned       ADDR_WIDTH = 12,
  parameter logic [WIDTH-1:0]  NOP_WORD   = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ld_we,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  input  logic [WIDTH-1:0]      ld_data,
  output logic                  ld_ready,
  input  logic                  f_req,
  input  logic [ADDR_WIDTH-1:0] f_addr,
  input  logic                  f_stall,
  output logic                  f_ready,
  output logic [WIDTH-1:0]      instruction,
  output logic                  f_valid,
  output logic                  f_err
);

  localparam int unsigned          IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0]  DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [IDX_W-1:0]     LAST_IDX  = IDX_W'(DEPTH - 1);

  typedef enum logic {S_INIT, S_READY} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   fill_q, fill_d;
  logic [WIDTH-1:0]   instr_q, instr_d;
  logic               valid_q, valid_d;
  logic               err_q, err_d;
  logic               ready_q, ready_d;

  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic               mem_we;
  logic [IDX_W-1:0]   mem_waddr;
  logic [WIDTH-1:0]   mem_wdata;

  logic               ld_in_range;
  logic               f_in_range;
  logic               ld_accept;
  logic               f_accept;
  logic               hold;

  assign ld_in_range = {1'b0, ld_addr} < DEPTH_LIM;
  assign f_in_range  = {1'b0, f_addr} < DEPTH_LIM;
  assign hold        = f_stall & valid_q;
  assign ld_accept   = ld_we & ready_q & ld_in_range;
  assign f_accept    = f_req & ready_q & ~hold;

  // Next-state, memory write port and fetch output selection
  always_comb begin
    state_d   = state_q;
    fill_d    = fill_q;
    instr_d   = instr_q;
    valid_d   = valid_q;
    err_d     = err_q;
    ready_d   = ready_q;
    mem_we    = 1'b0;
    mem_waddr = ld_addr[IDX_W-1:0];
    mem_wdata = ld_data;

    case (state_q)
      S_INIT: begin
        mem_we    = 1'b1;
        mem_waddr = fill_q;
        mem_wdata = NOP_WORD;
        valid_d   = 1'b0;
        err_d     = 1'b0;
        if (fill_q == LAST_IDX) begin
          state_d = S_READY;
          ready_d = 1'b1;
          fill_d  = '0;
        end else begin
          fill_d = fill_q + IDX_W'(1);
        end
      end
      S_READY: begin
        mem_we = ld_accept;
        if (f_accept) begin
          valid_d = 1'b1;
          if (f_in_range) begin
            err_d = 1'b0;
            // Write-first: a same-cycle write to the fetched word wins
            instr_d = (ld_accept && (ld_addr == f_addr)) ? ld_data
                                                         : mem_q[f_addr[IDX_W-1:0]];
          end else begin
            err_d   = 1'b1;
            instr_d = NOP_WORD;
          end
        end else if (!hold) begin
          valid_d = 1'b0;
          err_d   = 1'b0;
        end
      end
      default: begin
        state_d = S_INIT;
        fill_d  = '0;
        ready_d = 1'b0;
      end
    endcase
  end

  // Control and fetch-output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_INIT;
      fill_q  <= '0;
      instr_q <= NOP_WORD;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      ready_q <= ready_d;
    end
  end

  // Storage array; reset blocks writes, contents are rebuilt by the fill
  always_ff @(posedge clk) begin
    if (mem_we && !reset) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign ld_ready    = ready_q;
  assign f_ready     = ready_q & ~hold;
  assign instruction = instr_q;
  assign f_valid     = valid_q;
  assign f_err       = err_q;

endmodule

// File: tb/tb_instr_mem_ctrl.sv
// Scoreboard bench for instr_mem_ctrl: a main instance (DEPTH=12, 4-bit
// addresses, non-zero NOP) driven with directed and random traffic, and an
// idle DEPTH=16 instance used to check the fill length.
module tb_instr_mem_ctrl;

  localparam int unsigned DEPTH = 12;
  localparam int unsigned AW    = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  typedef struct packed {
    logic        v;
    logic        e;
    logic [31:0] ins;
    logic        rdy;
    logic        rdy16;
  } exp_t;

  logic          clk;
  logic          reset;
  logic          ld_we;
  logic [AW-1:0] ld_addr;
  logic [31:0]   ld_data;
  logic          f_req;
  logic [AW-1:0] f_addr;
  logic          f_stall;
  logic          ld_ready, f_ready, f_valid, f_err;
  logic [31:0]   instruction;

  logic          ld_ready16, f_ready16, f_valid16, f_err16;
  logic [31:0]   instruction16;

  int checks   = 0;
  int failures = 0;

  exp_t q[$];

  // Reference model state
  logic [31:0] mmem [16];
  bit          mready, mvalid, merr, mready16;
  logic [31:0] minstr;
  int          mfill, mfill16;

  instr_mem_ctrl #(
    .DEPTH(DEPTH), .WIDTH(32), .ADDR_WIDTH(AW), .NOP_WORD(NOP)
  ) u_dut (
    .clk(clk), .reset(reset),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ready(ld_ready),
    .f_req(f_req), .f_addr(f_addr), .f_stall(f_stall), .f_ready(f_ready),
    .instruction(instruction), .f_valid(f_valid), .f_err(f_err)
  );

  instr_mem_ctrl #(
    .DEPTH(16), .WIDTH(32), .ADDR_WIDTH(5), .NOP_WORD(32'h0000_0000)
  ) u_dut16 (
    .clk(clk), .reset(reset),
    .ld_we(1'b0), .ld_addr(5'd0), .ld_data(32'd0), .ld_ready(ld_ready16),
    .f_req(1'b0), .f_addr(5'd0), .f_stall(1'b0), .f_ready(f_ready16),
    .instruction(instruction16), .f_valid(f_valid16), .f_err(f_err16)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; the model predicts the outputs after the next edge
  task automatic cycle(input bit rst, input bit we, input logic [AW-1:0] wa,
                       input logic [31:0] wd, input bit req,
                       input logic [AW-1:0] fa, input bit st);
    exp_t e;
    bit   acc_w;
    @(negedge clk);
    reset   = rst;
    ld_we   = we;
    ld_addr = wa;
    ld_data = wd;
    f_req   = req;
    f_addr  = fa;
    f_stall = st;
    #1;
    chk("f_ready", 32'(f_ready), 32'(mready && !(st && mvalid)));
    chk("f_ready16", 32'(f_ready16), 32'(mready16));
    if (rst) begin
      mready = 0; mvalid = 0; merr = 0; minstr = NOP; mfill = 0;
      mready16 = 0; mfill16 = 0;
      for (int i = 0; i < 16; i++) mmem[i] = NOP;
    end else begin
      if (mready) begin
        acc_w = we && (32'(wa) < DEPTH);
        if (!(st && mvalid)) begin
          if (req) begin
            mvalid = 1;
            if (32'(fa) < DEPTH) begin
              merr   = 0;
              minstr = (acc_w && wa == fa) ? wd : mmem[fa];
            end else begin
              merr   = 1;
              minstr = NOP;
            end
          end else begin
            mvalid = 0;
            merr   = 0;
          end
        end
        if (acc_w) mmem[wa] = wd;
      end else begin
        mfill++;
        if (mfill == DEPTH) mready = 1;
      end
      if (!mready16) begin
        mfill16++;
        if (mfill16 == 16) mready16 = 1;
      end
    end
    e.v = mvalid; e.e = merr; e.ins = minstr; e.rdy = mready; e.rdy16 = mready16;
    q.push_back(e);
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 1'b0);
  endtask

  // Monitor: one expected entry per clock edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("f_valid", 32'(f_valid), 32'(e.v));
        chk("f_err", 32'(f_err), 32'(e.e));
        chk("instruction", instruction, e.ins);
        chk("ld_ready", 32'(ld_ready), 32'(e.rdy));
        chk("ld_ready16", 32'(ld_ready16), 32'(e.rdy16));
        chk("f_valid16", 32'(f_valid16), 32'd0);
        chk("f_err16", 32'(f_err16), 32'd0);
        chk("instruction16", instruction16, 32'd0);
      end
    end
  end

  initial begin
    reset = 1'b1; ld_we = 1'b0; ld_addr = '0; ld_data = '0;
    f_req = 1'b0; f_addr = '0; f_stall = 1'b0;
    mready = 0; mvalid = 0; merr = 0; minstr = NOP; mfill = 0;
    mready16 = 0; mfill16 = 0;
    for (int i = 0; i < 16; i++) mmem[i] = NOP;

    repeat (3) cycle(1'b1, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 1'b0);

    // Fill period: loader and fetch traffic must be ignored
    for (int i = 0; i < int'(DEPTH); i++)
      cycle(1'b0, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom,
            1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), 1'b0);

    // Every address after fill: NOP in range, error beyond DEPTH
    for (int i = 0; i < 16; i++) cycle(1'b0, 1'b0, 4'd0, 32'd0, 1'b1, AW'(i), 1'b0);
    idle();

    // Load two words and fetch them back-to-back
    cycle(1'b0, 1'b1, 4'd0, 32'h0000_A083, 1'b0, 4'd0, 1'b0);
    cycle(1'b0, 1'b1, 4'd1, 32'h0000_A103, 1'b0, 4'd0, 1'b0);
    cycle(1'b0, 1'b0, 4'd0, 32'd0, 1'b1, 4'd0, 1'b0);
    cycle(1'b0, 1'b0, 4'd0, 32'd0, 1'b1, 4'd1, 1'b0);
    idle();

    // Out-of-range fetch, dropped write, fetch again
    cycle(1'b0, 1'b0, 4'd0, 32'd0, 1'b1, 4'd13, 1'b0);
    cycle(1'b0, 1'b1, 4'd13, 32'hDEAD_BEEF, 1'b0, 4'd0, 1'b0);
    cycle(1'b0, 1'b0, 4'd0, 32'd0, 1'b1, 4'd13, 1'b0);
    idle();

    // Same-cycle write and fetch of one address
    cycle(1'b0, 1'b1, 4'd4, 32'h0020_8033, 1'b1, 4'd4, 1'b0);
    idle();

    // Stall holds the addr-1 word while addr 2 is requested
    cycle(1'b0, 1'b1, 4'd2, 32'h0030_0093, 1'b0, 4'd0, 1'b0);
    cycle(1'b0, 1'b0, 4'd0, 32'd0, 1'b1, 4'd1, 1'b0);
    repeat (3) cycle(1'b0, 1'b0, 4'd0, 32'd0, 1'b1, 4'd2, 1'b1);
    cycle(1'b0, 1'b0, 4'd0, 32'd0, 1'b1, 4'd2, 1'b0);
    idle();

    // Reset at fill count 5, then reset again with a valid fetch pending
    cycle(1'b1, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 1'b0);
    repeat (5) idle();
    cycle(1'b1, 1'b1, 4'd3, 32'h1234_5678, 1'b1, 4'd3, 1'b1);
    repeat (DEPTH + 4) idle();
    cycle(1'b0, 1'b1, 4'd3, 32'hCAFE_0003, 1'b1, 4'd3, 1'b0);
    cycle(1'b1, 1'b1, 4'd5, 32'h5555_5555, 1'b1, 4'd5, 1'b1);
    repeat (DEPTH + 4) idle();
    cycle(1'b0, 1'b0, 4'd0, 32'd0, 1'b1, 4'd3, 1'b0);
    idle();

    // Random traffic with occasional resets
    for (int n = 0; n < 600; n++) begin
      logic [AW-1:0] wa;
      logic [AW-1:0] fa;
      wa = AW'($urandom_range(0, 15));
      fa = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, 15));
      cycle(1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 1)), wa, $urandom,
            1'($urandom_range(0, 3) != 0), fa, 1'($urandom_range(0, 3) == 0));
    end
    idle();

    @(posedge clk);
    #2;
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_mem_ctrl.md
INSTR_MEM_CTRL -- requirements
Module: instr_mem_ctrl

Interface
REQ-001 Parameter DEPTH, 4096: number of instruction words stored.
REQ-002 Parameter WIDTH, 32: instruction word width in bits.
REQ-003 Parameter ADDR_WIDTH, 12: word-address width; DEPTH <= 2**ADDR_WIDTH.
REQ-004 Parameter NOP_WORD, 32'h0000_0000 (WIDTH bits): fill and fault word.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-007 ld_we  input  1  loader write strobe.
REQ-008 ld_addr  input  ADDR_WIDTH  loader word address.
REQ-009 ld_data  input  WIDTH  loader write data.
REQ-010 ld_ready  output  1  loader writes accepted this cycle.
REQ-011 f_req  input  1  fetch request.
REQ-012 f_addr  input  ADDR_WIDTH  fetch word address.
REQ-013 f_stall  input  1  consumer stall; holds fetch output.
REQ-014 f_ready  output  1  fetch requests accepted this cycle.
REQ-015 instruction  output  WIDTH  fetched instruction word.
REQ-016 f_valid  output  1  instruction holds a completed fetch.
REQ-017 f_err  output  1  fetch address was out of range (>= DEPTH).

Function
REQ-018 Controller SHALL have two states: INIT and READY.
REQ-019 INIT SHALL write NOP_WORD to one location per cycle, addresses 0..DEPTH-1 ascending, via an internal fill counter, then enter READY on the cycle after writing DEPTH-1 (DEPTH cycles total).
REQ-020 In INIT, ld_ready and f_ready SHALL be 0; ld_we and f_req SHALL be ignored.
REQ-021 In READY, ld_ready and f_ready SHALL be 1, except f_ready = 0 while f_stall = 1 and f_valid = 1.
REQ-022 Accepted write (ld_we & ld_ready, ld_addr < DEPTH) SHALL update memory at the rising edge; writes with ld_addr >= DEPTH SHALL be dropped silently.
REQ-023 Accepted fetch (f_req & f_ready) SHALL produce instruction, f_valid = 1, f_err in the following cycle (1-cycle latency).
REQ-024 Fetch with f_addr >= DEPTH SHALL return instruction = NOP_WORD, f_err = 1; otherwise f_err = 0.
REQ-025 Same-cycle accepted write and fetch to the same in-range address SHALL return ld_data (write-first bypass).
REQ-026 With f_stall = 1 and f_valid = 1, instruction, f_valid and f_err SHALL hold unchanged, and f_req SHALL not be accepted; loader writes remain accepted.
REQ-027 Cycle with no accepted fetch and f_stall = 0 SHALL drive f_valid = 0 and f_err = 0 the next cycle; instruction SHALL hold its last value.
REQ-028 Back-to-back accepted fetches SHALL sustain one instruction per cycle.

Reset
REQ-029 reset = 1 SHALL force state INIT, fill counter 0, instruction = NOP_WORD, f_valid = 0, f_err = 0, ld_ready = 0, f_ready = 0 on the next edge.
REQ-030 reset asserted mid-INIT or mid-READY SHALL restart the full fill; in-flight fetch SHALL be discarded (f_valid = 0).
REQ-031 reset SHALL have priority over ld_we, f_req and f_stall in the same cycle.
REQ-032 Memory contents written before reset SHALL be overwritten with NOP_WORD by the subsequent INIT fill.

Verification
REQ-033 Release reset, DEPTH=16 -> ld_ready/f_ready rise exactly 16 cycles later; fetch of addresses 0..15 returns NOP_WORD, f_err=0.
REQ-034 Load addr 0 = 32'h0000A083, addr 1 = 32'h0000A103, then fetch 0,1 back-to-back -> instruction 32'h0000A083 then 32'h0000A103 on consecutive cycles, f_valid=1 both.
REQ-035 DEPTH=12, ADDR_WIDTH=4: fetch addr 13 -> instruction = NOP_WORD, f_err=1; write to addr 13 then fetch addr 13 again -> still NOP_WORD, f_err=1.
REQ-036 Same cycle ld_we addr 4 data 32'h00208033 and f_req addr 4 -> next cycle instruction = 32'h00208033.
REQ-037 Fetch addr 1 valid, assert f_stall 3 cycles with f_req addr 2 held -> instruction stays addr-1 word, f_ready=0 for 3 cycles; addr-2 word appears 1 cycle after f_stall drops.
REQ-038 Assert reset at fill counter 5 of INIT, and again in READY with f_valid=1 -> f_valid=0 next edge, fill restarts at 0, READY after DEPTH more cycles.
